// File: rtl/point_pkg.sv
// Types shared by the point pipeline: packed point layout, bounding box and
// the tracker state encoding.
package point_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } point_t;

  typedef struct packed {
    logic [15:0] xmin;
    logic [15:0] ymin;
    logic [15:0] xmax;
    logic [15:0] ymax;
  } bbox_t;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

endpackage

// File: rtl/point_minmax.sv
// Combinational bounding-box update: folds one point into a box, or seeds the
// box from the point when it is the first of a window.
module point_minmax
  import point_pkg::*;
(
  input  bbox_t  cur,
  input  point_t pt,
  input  logic   first,
  output bbox_t  nxt
);

  always_comb begin
    nxt = cur;
    if (first) begin
      nxt.xmin = pt.x;
      nxt.xmax = pt.x;
      nxt.ymin = pt.y;
      nxt.ymax = pt.y;
    end else begin
      if (pt.x < cur.xmin) nxt.xmin = pt.x;
      if (pt.x > cur.xmax) nxt.xmax = pt.x;
      if (pt.y < cur.ymin) nxt.ymin = pt.y;
      if (pt.y > cur.ymax) nxt.ymax = pt.y;
    end
  end

endmodule

// File: rtl/point_bbox_tracker.sv
// Accumulates a window of points into a bounding box, count and per-axis sums,
// and emits one record per window over a valid/ready interface.
module point_bbox_tracker
  import point_pkg::*;
#(
  parameter int WINDOW = 8,
  localparam int CW = $clog2(WINDOW + 1),
  localparam int SW = 16 + $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   in_pt,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [63:0]   out_bbox,
  output logic [CW-1:0] out_count,
  output logic [SW-1:0] out_xsum,
  output logic [SW-1:0] out_ysum,
  output logic          out_valid,
  input  logic          out_ready
);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  bbox_t         acc_bbox;
  bbox_t         bbox_next;
  logic [SW-1:0] acc_xsum;
  logic [SW-1:0] acc_ysum;
  logic [SW-1:0] xsum_next;
  logic [SW-1:0] ysum_next;
  point_t        pt;
  logic          accept;
  logic          first;
  logic          last_point;
  logic          close;

  assign pt         = in_pt;
  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == EMIT);
  assign accept     = in_valid && in_ready;
  assign first      = (cnt == '0);
  assign last_point = (cnt == CW'(WINDOW - 1));

  // A window closes when it fills, or on flush as long as it holds at least one
  // point once a same-cycle accept is counted.
  assign close = in_ready && ((accept && last_point) || (flush && (!first || accept)));

  point_minmax u_minmax (
    .cur   (acc_bbox),
    .pt    (pt),
    .first (first),
    .nxt   (bbox_next)
  );

  assign xsum_next = first ? SW'(pt.x) : acc_xsum + SW'(pt.x);
  assign ysum_next = first ? SW'(pt.y) : acc_ysum + SW'(pt.y);

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (close) state_next = EMIT;
      EMIT:    if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Output registers are loaded only on the closing edge, so they stay stable
  // for the whole EMIT phase regardless of backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc_bbox  <= '0;
      acc_xsum  <= '0;
      acc_ysum  <= '0;
      out_bbox  <= '0;
      out_count <= '0;
      out_xsum  <= '0;
      out_ysum  <= '0;
    end else begin
      if (accept) begin
        acc_bbox <= bbox_next;
        acc_xsum <= xsum_next;
        acc_ysum <= ysum_next;
        cnt      <= cnt + CW'(1);
      end
      if (close) begin
        out_bbox  <= accept ? bbox_next : acc_bbox;
        out_xsum  <= accept ? xsum_next : acc_xsum;
        out_ysum  <= accept ? ysum_next : acc_ysum;
        out_count <= cnt + CW'(accept);
        cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_point_bbox_tracker.sv
// Scoreboard bench for point_bbox_tracker: directed windows with hand-computed
// records, plus a WINDOW=1 instance for the single-point case.
module tb_point_bbox_tracker;
  import point_pkg::*;

  localparam int WINDOW = 4;
  localparam int CW = 3;
  localparam int SW = 19;

  typedef struct packed {
    logic [63:0]   bbox;
    logic [CW-1:0] count;
    logic [SW-1:0] xsum;
    logic [SW-1:0] ysum;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in_pt;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [63:0]   out_bbox;
  logic [CW-1:0] out_count;
  logic [SW-1:0] out_xsum;
  logic [SW-1:0] out_ysum;
  logic          out_valid;
  logic          out_ready;

  logic [31:0]   in_pt1;
  logic          in_valid1;
  logic          in_ready1;
  logic          flush1;
  logic [63:0]   out_bbox1;
  logic [0:0]    out_count1;
  logic [16:0]   out_xsum1;
  logic [16:0]   out_ysum1;
  logic          out_valid1;
  logic          out_ready1;

  int   checks = 0;
  int   failures = 0;
  rec_t exp_q[$];

  point_bbox_tracker #(.WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst), .in_pt(in_pt), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_bbox(out_bbox), .out_count(out_count), .out_xsum(out_xsum),
    .out_ysum(out_ysum), .out_valid(out_valid), .out_ready(out_ready)
  );

  point_bbox_tracker #(.WINDOW(1)) dut1 (
    .clk(clk), .rst(rst), .in_pt(in_pt1), .in_valid(in_valid1), .in_ready(in_ready1),
    .flush(flush1), .out_bbox(out_bbox1), .out_count(out_count1), .out_xsum(out_xsum1),
    .out_ysum(out_ysum1), .out_valid(out_valid1), .out_ready(out_ready1)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] xmin, input logic [15:0] ymin,
                          input logic [15:0] xmax, input logic [15:0] ymax,
                          input int count, input int xs, input int ys);
    rec_t r;
    r.bbox  = {xmin, ymin, xmax, ymax};
    r.count = CW'(count);
    r.xsum  = SW'(xs);
    r.ysum  = SW'(ys);
    exp_q.push_back(r);
  endtask

  // Called at a negedge; holds the point until it is accepted, returns at the
  // negedge following the accepting edge.
  task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] y, input logic do_flush);
    int   guard;
    logic took;
    guard    = 0;
    took     = 1'b0;
    in_pt    = {x, y};
    in_valid = 1'b1;
    flush    = do_flush;
    while (!took && guard < 50) begin
      took = in_ready;
      @(negedge clk);
      flush = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    if (!took) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=not_accepted expected=accepted");
    end
  endtask

  task automatic apply_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every record handshake and checks that a
  // stalled record does not change while backpressured.
  initial begin : monitor
    logic held;
    rec_t saved;
    rec_t got;
    rec_t exp;
    held = 1'b0;
    saved = '0;
    forever begin
      @(negedge clk);
      #2;
      got = {out_bbox, out_count, out_xsum, out_ysum};
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check_output("hold_valid", out_valid, 1);
          check_output("hold_data", got, saved);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_record actual=%0h expected=none", got);
          end else begin
            exp = exp_q.pop_front();
            check_output("rec_bbox", out_bbox, exp.bbox);
            check_output("rec_count", out_count, exp.count);
            check_output("rec_xsum", out_xsum, exp.xsum);
            check_output("rec_ysum", out_ysum, exp.ysum);
          end
          held = 1'b0;
        end else if (out_valid) begin
          held = 1'b1;
          saved = got;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_pt = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pt1 = '0; in_valid1 = 1'b0; flush1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_output("reset_valid", out_valid, 0);
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_bbox", out_bbox, 0);
    check_output("reset_count", out_count, 0);
    check_output("reset_sums", {out_xsum, out_ysum}, 0);

    // Back-to-back full window with a one-cycle bubble
    push_exp(1, 3, 4, 12, 4, 10, 30);
    apply_stimulus(1, 3, 0);
    apply_stimulus(2, 6, 0);
    apply_stimulus(3, 9, 0);
    apply_stimulus(4, 12, 0);
    check_output("t1_out_valid", out_valid, 1);
    check_output("t1_in_ready_low", in_ready, 0);
    @(negedge clk);
    check_output("t1_in_ready_back", in_ready, 1);

    // Backpressure: record held 4 cycles, next point waits for the handshake
    out_ready = 1'b0;
    push_exp(1, 3, 4, 12, 4, 10, 30);
    push_exp(50, 100, 150, 300, 4, 375, 850);
    apply_stimulus(1, 3, 0);
    apply_stimulus(2, 6, 0);
    apply_stimulus(3, 9, 0);
    apply_stimulus(4, 12, 0);
    fork
      apply_stimulus(100, 200, 0);
      begin
        check_output("t2_in_ready_0", in_ready, 0);
        @(negedge clk);
        check_output("t2_in_ready_1", in_ready, 0);
        @(negedge clk);
        check_output("t2_in_ready_2", in_ready, 0);
        @(negedge clk);
        check_output("t2_in_ready_3", in_ready, 0);
        check_output("t2_out_valid", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check_output("t2_in_ready_after", in_ready, 1);
      end
    join
    apply_stimulus(50, 300, 0);
    apply_stimulus(150, 100, 0);
    apply_stimulus(75, 250, 0);
    @(negedge clk);

    // Flush of a partial window, then flush of an empty window
    push_exp(5, 2, 10, 16'hFFFF, 2, 15, 32'h10001);
    apply_stimulus(10, 16'hFFFF, 0);
    apply_stimulus(5, 2, 0);
    apply_flush();
    check_output("t3_flush_valid", out_valid, 1);
    @(negedge clk);
    @(negedge clk);
    apply_flush();
    for (int i = 0; i < 3; i++) begin
      check_output("t3_empty_flush_valid", out_valid, 0);
      check_output("t3_empty_flush_ready", in_ready, 1);
      @(negedge clk);
    end

    // Flush coincident with the accept of the third point
    push_exp(1, 0, 9, 7, 3, 17, 8);
    apply_stimulus(1, 1, 0);
    apply_stimulus(9, 0, 0);
    apply_stimulus(7, 7, 1);
    check_output("t4_valid", out_valid, 1);
    @(negedge clk);

    // Extreme coordinates
    push_exp(0, 0, 16'hFFFF, 0, 4, 32'h1FFFE, 0);
    apply_stimulus(16'hFFFF, 0, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(16'hFFFF, 0, 0);
    apply_stimulus(0, 0, 0);
    @(negedge clk);

    // Reset mid-window discards the partial accumulation
    apply_stimulus(900, 900, 0);
    apply_stimulus(1, 1, 0);
    apply_stimulus(800, 7, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("t6_mid_valid", out_valid, 0);
    check_output("t6_mid_ready", in_ready, 1);
    check_output("t6_mid_count", out_count, 0);
    push_exp(20, 5, 30, 50, 4, 96, 105);
    apply_stimulus(20, 40, 0);
    apply_stimulus(30, 10, 0);
    apply_stimulus(25, 50, 0);
    apply_stimulus(21, 5, 0);
    @(negedge clk);

    // Reset during EMIT drops the pending record
    out_ready = 1'b0;
    apply_stimulus(600, 600, 0);
    apply_stimulus(601, 601, 0);
    apply_stimulus(602, 602, 0);
    apply_stimulus(603, 603, 0);
    check_output("t6_emit_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("t6_emit_dropped", out_valid, 0);
    check_output("t6_emit_ready", in_ready, 1);
    out_ready = 1'b1;
    push_exp(2, 2, 5, 5, 4, 14, 14);
    apply_stimulus(2, 2, 0);
    apply_stimulus(3, 3, 0);
    apply_stimulus(4, 4, 0);
    apply_stimulus(5, 5, 0);
    @(negedge clk);

    // WINDOW=1: each accepted point is its own record
    check_output("w1_in_ready", in_ready1, 1);
    in_pt1 = {16'h1234, 16'h0042};
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    check_output("w1_valid", out_valid1, 1);
    check_output("w1_count", out_count1, 1);
    check_output("w1_bbox", out_bbox1, 64'h1234_0042_1234_0042);
    check_output("w1_sums", {out_xsum1, out_ysum1}, {17'h01234, 17'h00042});
    @(negedge clk);
    check_output("w1_in_ready_again", in_ready1, 1);
    in_pt1 = {16'hFFFF, 16'hFFFF};
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    check_output("w1_max_bbox", out_bbox1, 64'hFFFF_FFFF_FFFF_FFFF);
    check_output("w1_max_sums", {out_xsum1, out_ysum1}, {17'h0FFFF, 17'h0FFFF});

    repeat (3) @(negedge clk);
    check_output("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
